gas_param_sequencer: RTL and testbench

GAS_PARAM_SEQUENCER -- requirements
Module: gas_param_sequencer

---
 rtl/gas_param_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_gas_param_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/gas_param_sequencer.sv
// Gas-simulation parameter sequencer: per-channel key trackers feed a
// round-robin arbiter that steps one bounded parameter per request/ack handshake.
module gas_param_sequencer #(
    parameter int MAX_MOLES = 5,
    parameter int MAX_TEMP  = 7,
    parameter int MAX_VOL   = 7,
    parameter int MIN_VAL   = 1
) (
    input  logic       clk,
    input  logic       Reset_n,
    input  logic [2:0] keyIncr,
    input  logic [2:0] keyDecr,
    input  logic       updateAck,
    output logic [2:0] numMoles,
    output logic [2:0] temperature,
    output logic [2:0] volume,
    output logic       updateReq,
    output logic [1:0] updateSel,
    output logic       limitHit
);

    // Arbiter states
    //   ARB_IDLE  | waiting for a pending channel; grants round-robin
    //   ARB_APPLY | one cycle: clear pending, step value or flag a bound hit
    //   ARB_REQ   | updateReq held with updateSel until updateAck
    // Tracker states (one per channel)
    //   TRK_IDLE  | no key held on this channel
    //   TRK_HELD  | a key is held; direction frozen until release
    typedef enum logic [1:0] {ARB_IDLE, ARB_APPLY, ARB_REQ} arb_state_t;
    typedef enum logic {TRK_IDLE, TRK_HELD} trk_state_t;

    localparam logic [2:0] MIN_V = 3'(MIN_VAL);

    arb_state_t state_q, state_nx;
    trk_state_t trk_q [3];
    trk_state_t trk_nx [3];

    logic [2:0] dir_q, dir_nx;
    logic [2:0] pend_q, pend_nx;
    logic [2:0] pend_dir_q, pend_dir_nx;
    logic [2:0] vals_q [3];
    logic [2:0] vals_nx [3];
    logic [1:0] grant_q, grant_nx;
    logic [1:0] last_q, last_nx;
    logic       limit_q, limit_nx;

    logic [2:0] key_any;
    logic [2:0] released;
    logic [2:0] cur_val;
    logic [2:0] cur_max;
    logic       cur_up;
    logic       at_bound;
    logic [1:0] rr_pick;

    function automatic logic [1:0] pick_first(input logic [2:0] req,
                                              input logic [1:0] a,
                                              input logic [1:0] b,
                                              input logic [1:0] c);
        logic [1:0] r;
        r = c;
        if (req[c])
            r = c;
        if (req[b])
            r = b;
        if (req[a])
            r = a;
        return r;
    endfunction

    assign key_any = keyIncr | keyDecr;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            released[i] = (trk_q[i] == TRK_HELD) && !key_any[i];
        end
    end

    // Trackers run regardless of arbiter state so presses during REQ are kept.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            trk_nx[i] = trk_q[i];
            dir_nx[i] = dir_q[i];
            case (trk_q[i])
                TRK_IDLE: begin
                    if (key_any[i]) begin
                        trk_nx[i] = TRK_HELD;
                        dir_nx[i] = keyIncr[i];
                    end
                end
                TRK_HELD: begin
                    if (!key_any[i])
                        trk_nx[i] = TRK_IDLE;
                end
                default: trk_nx[i] = TRK_IDLE;
            endcase
        end
    end

    // Search starts after the last granted channel.
    always_comb begin
        case (last_q)
            2'd0:    rr_pick = pick_first(pend_q, 2'd1, 2'd2, 2'd0);
            2'd1:    rr_pick = pick_first(pend_q, 2'd2, 2'd0, 2'd1);
            default: rr_pick = pick_first(pend_q, 2'd0, 2'd1, 2'd2);
        endcase
    end

    always_comb begin
        case (grant_q)
            2'd0:    begin cur_val = vals_q[0]; cur_max = 3'(MAX_MOLES); end
            2'd1:    begin cur_val = vals_q[1]; cur_max = 3'(MAX_TEMP);  end
            default: begin cur_val = vals_q[2]; cur_max = 3'(MAX_VOL);   end
        endcase
        cur_up   = pend_dir_q[grant_q];
        at_bound = cur_up ? (cur_val >= cur_max) : (cur_val <= MIN_V);
    end

    always_comb begin
        state_nx    = state_q;
        grant_nx    = grant_q;
        last_nx     = last_q;
        limit_nx    = 1'b0;
        pend_nx     = pend_q;
        pend_dir_nx = pend_dir_q;
        for (int i = 0; i < 3; i++)
            vals_nx[i] = vals_q[i];

        // A release landing on an already-pending channel is dropped.
        for (int i = 0; i < 3; i++) begin
            if (released[i] && !pend_q[i]) begin
                pend_nx[i]     = 1'b1;
                pend_dir_nx[i] = dir_q[i];
            end
        end

        case (state_q)
            ARB_IDLE: begin
                if (|pend_q) begin
                    grant_nx = rr_pick;
                    state_nx = ARB_APPLY;
                end
            end
            ARB_APPLY: begin
                for (int i = 0; i < 3; i++) begin
                    if (2'(i) == grant_q) begin
                        pend_nx[i] = 1'b0;
                        if (!at_bound)
                            vals_nx[i] = cur_up ? (cur_val + 3'd1) : (cur_val - 3'd1);
                    end
                end
                if (at_bound) begin
                    // Recording the grant here lets round-robin move past a saturated channel.
                    limit_nx = 1'b1;
                    last_nx  = grant_q;
                    state_nx = ARB_IDLE;
                end else begin
                    state_nx = ARB_REQ;
                end
            end
            ARB_REQ: begin
                if (updateAck) begin
                    last_nx  = grant_q;
                    state_nx = ARB_IDLE;
                end
            end
            default: state_nx = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= ARB_IDLE;
            grant_q    <= 2'd0;
            last_q     <= 2'd2;
            limit_q    <= 1'b0;
            dir_q      <= 3'b000;
            pend_q     <= 3'b000;
            pend_dir_q <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                trk_q[i]  <= TRK_IDLE;
                vals_q[i] <= MIN_V;
            end
        end else begin
            state_q    <= state_nx;
            grant_q    <= grant_nx;
            last_q     <= last_nx;
            limit_q    <= limit_nx;
            dir_q      <= dir_nx;
            pend_q     <= pend_nx;
            pend_dir_q <= pend_dir_nx;
            for (int i = 0; i < 3; i++) begin
                trk_q[i]  <= trk_nx[i];
                vals_q[i] <= vals_nx[i];
            end
        end
    end

    assign numMoles    = vals_q[0];
    assign temperature = vals_q[1];
    assign volume      = vals_q[2];
    assign updateReq   = (state_q == ARB_REQ);
    assign updateSel   = (state_q == ARB_REQ) ? grant_q : 2'd0;
    assign limitHit    = limit_q;

endmodule

// File: tb/tb_gas_param_sequencer.sv
// Directed bench for gas_param_sequencer: handshake latency, saturation,
// round-robin ordering, queued presses during REQ and asynchronous reset.
module tb_gas_param_sequencer;

    logic       clk;
    logic       Reset_n;
    logic [2:0] keyIncr;
    logic [2:0] keyDecr;
    logic       updateAck;
    logic [2:0] numMoles;
    logic [2:0] temperature;
    logic [2:0] volume;
    logic       updateReq;
    logic [1:0] updateSel;
    logic       limitHit;

    int total = 0;
    int bad   = 0;

    gas_param_sequencer dut (
        .clk         (clk),
        .Reset_n     (Reset_n),
        .keyIncr     (keyIncr),
        .keyDecr     (keyDecr),
        .updateAck   (updateAck),
        .numMoles    (numMoles),
        .temperature (temperature),
        .volume      (volume),
        .updateReq   (updateReq),
        .updateSel   (updateSel),
        .limitHit    (limitHit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        Reset_n   = 1'b0;
        keyIncr   = 3'b000;
        keyDecr   = 3'b000;
        updateAck = 1'b0;
        cyc(2);
        Reset_n = 1'b1;
    endtask

    // Press for one cycle, release; returns positioned #1 after release edge E.
    task automatic tap(input logic [2:0] inc, input logic [2:0] dec);
        keyIncr = inc;
        keyDecr = dec;
        cyc(1);
        keyIncr = 3'b000;
        keyDecr = 3'b000;
        cyc(1);
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (numMoles !== 3'd1) begin bad++; $display("FAIL rst_moles got=%0d exp=1", numMoles); end
        total++; if (temperature !== 3'd1) begin bad++; $display("FAIL rst_temp got=%0d exp=1", temperature); end
        total++; if (volume !== 3'd1) begin bad++; $display("FAIL rst_vol got=%0d exp=1", volume); end
        total++; if (updateReq !== 1'b0) begin bad++; $display("FAIL rst_req got=%0d exp=0", updateReq); end
        total++; if (updateSel !== 2'd0) begin bad++; $display("FAIL rst_sel got=%0d exp=0", updateSel); end
        total++; if (limitHit !== 1'b0) begin bad++; $display("FAIL rst_limit got=%0d exp=0", limitHit); end
    endtask

    task automatic test_single_incr();
        do_reset();
        keyIncr = 3'b001;
        cyc(3);
        keyIncr = 3'b000;
        cyc(1);
        total++; if (updateReq !== 1'b0) begin bad++; $display("FAIL s1_req_e got=%0d exp=0", updateReq); end
        cyc(1);
        total++; if (numMoles !== 3'd1) begin bad++; $display("FAIL s1_moles_e1 got=%0d exp=1", numMoles); end
        total++; if (updateReq !== 1'b0) begin bad++; $display("FAIL s1_req_e1 got=%0d exp=0", updateReq); end
        cyc(1);
        total++; if (numMoles !== 3'd2) begin bad++; $display("FAIL s1_moles_e2 got=%0d exp=2", numMoles); end
        total++; if (updateReq !== 1'b1) begin bad++; $display("FAIL s1_req_e2 got=%0d exp=1", updateReq); end
        total++; if (updateSel !== 2'd0) begin bad++; $display("FAIL s1_sel_e2 got=%0d exp=0", updateSel); end
        cyc(1);
        total++; if (updateReq !== 1'b1) begin bad++; $display("FAIL s1_req_e3 got=%0d exp=1", updateReq); end
        updateAck = 1'b1;
        cyc(1);
        updateAck = 1'b0;
        total++; if (updateReq !== 1'b0) begin bad++; $display("FAIL s1_req_ack got=%0d exp=0", updateReq); end
        total++; if (numMoles !== 3'd2) begin bad++; $display("FAIL s1_moles_end got=%0d exp=2", numMoles); end
    endtask

    task automatic test_saturate();
        logic [2:0] exp_val;
        logic       exp_req;
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            exp_val = (k < 4) ? 3'(1 + k) : 3'd5;
            exp_req = (k <= 4);
            tap(3'b001, 3'b000);
            cyc(2);
            total++; if (numMoles !== exp_val) begin bad++; $display("FAIL sat_val k=%0d got=%0d exp=%0d", k, numMoles, exp_val); end
            total++; if (updateReq !== exp_req) begin bad++; $display("FAIL sat_req k=%0d got=%0d exp=%0d", k, updateReq, exp_req); end
            total++; if (limitHit !== !exp_req) begin bad++; $display("FAIL sat_limit k=%0d got=%0d exp=%0d", k, limitHit, !exp_req); end
            if (exp_req) begin
                updateAck = 1'b1;
                cyc(1);
                updateAck = 1'b0;
            end else begin
                cyc(1);
                total++; if (limitHit !== 1'b0) begin bad++; $display("FAIL sat_pulse k=%0d got=%0d exp=0", k, limitHit); end
            end
            cyc(1);
        end
    endtask

    task automatic test_decr_floor();
        do_reset();
        tap(3'b000, 3'b010);
        cyc(2);
        total++; if (temperature !== 3'd1) begin bad++; $display("FAIL dec_temp got=%0d exp=1", temperature); end
        total++; if (limitHit !== 1'b1) begin bad++; $display("FAIL dec_limit got=%0d exp=1", limitHit); end
        total++; if (updateReq !== 1'b0) begin bad++; $display("FAIL dec_req got=%0d exp=0", updateReq); end
        cyc(1);
        total++; if (limitHit !== 1'b0) begin bad++; $display("FAIL dec_pulse got=%0d exp=0", limitHit); end
        total++; if (updateReq !== 1'b0) begin bad++; $display("FAIL dec_req2 got=%0d exp=0", updateReq); end
    endtask

    task automatic test_round_robin();
        logic       exp_req;
        logic [1:0] exp_sel;
        do_reset();
        updateAck = 1'b1;
        tap(3'b111, 3'b000);
        for (int c = 1; c <= 9; c++) begin
            cyc(1);
            exp_req = (c == 2) || (c == 5) || (c == 8);
            exp_sel = (c == 8) ? 2'd2 : (c == 5) ? 2'd1 : 2'd0;
            total++; if (updateReq !== exp_req) begin bad++; $display("FAIL rr_req c=%0d got=%0d exp=%0d", c, updateReq, exp_req); end
            if (exp_req) begin
                total++; if (updateSel !== exp_sel) begin bad++; $display("FAIL rr_sel c=%0d got=%0d exp=%0d", c, updateSel, exp_sel); end
            end
            if (c == 4) begin
                total++; if (temperature !== 3'd1) begin bad++; $display("FAIL rr_temp_early got=%0d exp=1", temperature); end
            end
        end
        updateAck = 1'b0;
        total++; if (numMoles !== 3'd2) begin bad++; $display("FAIL rr_moles got=%0d exp=2", numMoles); end
        total++; if (temperature !== 3'd2) begin bad++; $display("FAIL rr_temp got=%0d exp=2", temperature); end
        total++; if (volume !== 3'd2) begin bad++; $display("FAIL rr_vol got=%0d exp=2", volume); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        tap(3'b100, 3'b000);
        cyc(2);
        total++; if (volume !== 3'd2) begin bad++; $display("FAIL b2b_vol1 got=%0d exp=2", volume); end
        total++; if (updateSel !== 2'd2) begin bad++; $display("FAIL b2b_sel got=%0d exp=2", updateSel); end
        tap(3'b100, 3'b000);
        tap(3'b100, 3'b000);
        cyc(1);
        total++; if (updateReq !== 1'b1) begin bad++; $display("FAIL b2b_req_held got=%0d exp=1", updateReq); end
        total++; if (volume !== 3'd2) begin bad++; $display("FAIL b2b_vol_held got=%0d exp=2", volume); end
        updateAck = 1'b1;
        cyc(1);
        updateAck = 1'b0;
        total++; if (updateReq !== 1'b0) begin bad++; $display("FAIL b2b_req_ack got=%0d exp=0", updateReq); end
        cyc(2);
        total++; if (volume !== 3'd3) begin bad++; $display("FAIL b2b_vol2 got=%0d exp=3", volume); end
        total++; if (updateReq !== 1'b1) begin bad++; $display("FAIL b2b_req2 got=%0d exp=1", updateReq); end
        updateAck = 1'b1;
        cyc(1);
        updateAck = 1'b0;
        cyc(5);
        total++; if (volume !== 3'd3) begin bad++; $display("FAIL b2b_vol_end got=%0d exp=3", volume); end
        total++; if (updateReq !== 1'b0) begin bad++; $display("FAIL b2b_req_end got=%0d exp=0", updateReq); end
    endtask

    task automatic test_both_keys_and_reset();
        do_reset();
        tap(3'b100, 3'b100);
        cyc(2);
        total++; if (volume !== 3'd2) begin bad++; $display("FAIL both_vol got=%0d exp=2", volume); end
        total++; if (updateReq !== 1'b1) begin bad++; $display("FAIL both_req got=%0d exp=1", updateReq); end
        #2;
        Reset_n = 1'b0;
        #1;
        total++; if (updateReq !== 1'b0) begin bad++; $display("FAIL arst_req got=%0d exp=0", updateReq); end
        total++; if (volume !== 3'd1) begin bad++; $display("FAIL arst_vol got=%0d exp=1", volume); end
        total++; if (updateSel !== 2'd0) begin bad++; $display("FAIL arst_sel got=%0d exp=0", updateSel); end
        cyc(1);
        Reset_n = 1'b1;
        cyc(4);
        total++; if (updateReq !== 1'b0) begin bad++; $display("FAIL post_rst_req got=%0d exp=0", updateReq); end
        total++; if ({numMoles, temperature, volume} !== 9'b001_001_001) begin bad++; $display("FAIL post_rst_vals got=%0d/%0d/%0d exp=1/1/1", numMoles, temperature, volume); end
    endtask

    initial begin
        Reset_n   = 1'b0;
        keyIncr   = 3'b000;
        keyDecr   = 3'b000;
        updateAck = 1'b0;
        test_reset();
        test_single_incr();
        test_saturate();
        test_decr_floor();
        test_round_robin();
        test_back_to_back();
        test_both_keys_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
